// File: rtl/pll_reset_sequencer_pkg.sv
// Shared constants for the PLL reset sequencer: seq_state encoding used by status/debug logic
// and a counter-width helper.
package pll_reset_sequencer_pkg;

    localparam logic [1:0] SEQ_HOLD   = 2'd0;
    localparam logic [1:0] SEQ_STABLE = 2'd1;
    localparam logic [1:0] SEQ_REL0   = 2'd2;
    localparam logic [1:0] SEQ_RUN    = 2'd3;

    // Width able to hold 0..max(a,b)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 32'sd1) ? $clog2(m) : 32'sd1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_debounce.sv
// 2-FF synchroniser followed by a level debouncer: a new level is accepted only after
// the synchronised input has differed from the accepted level for DEBOUNCE_CYCLES edges.
module pll_reset_sequencer_sync_debounce
    import pll_reset_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din_i,
    output logic db_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES, 32'sd2);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 32'sd1);

    logic          meta_q;
    logic          sync_q;
    logic          db_q;
    logic          db_d;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // Any return to the accepted level discards progress, so bounces never accumulate.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            db_d  = sync_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DW'(1);
        end
    end

    // Synchroniser and debounce state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged reset generator for the clkIO domain: releases rst_io once the PLL lock has been
// stable, then rst_cpu STAGE_GAP cycles later; lock loss or the button re-asserts both.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int DEBOUNCE_CYCLES    = 65536
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       btn_reset,
    output logic       rst_io,
    output logic       rst_cpu,
    output logic [1:0] seq_state,
    output logic [7:0] lock_loss_count
);

    localparam int CW = cnt_width(LOCK_STABLE_CYCLES, STAGE_GAP);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 32'sd1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 32'sd1);

    logic          lock_meta_q;
    logic          locked_q;
    logic          btn_db_s;
    logic          go_hold_s;
    logic          lost_s;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [7:0]    loss_q;
    logic [7:0]    loss_d;
    logic          rst_io_q;
    logic          rst_cpu_q;

    pll_reset_sequencer_sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clock  (clock),
        .reset_n(reset_n),
        .din_i  (btn_reset),
        .db_o   (btn_db_s)
    );

    assign go_hold_s = !locked_q || btn_db_s;
    // Only lock-caused exits from an active state are counted; the lock condition wins ties.
    assign lost_s    = (state_q != SEQ_HOLD) && !locked_q;

    // Sequencer next state and shared stage counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SEQ_HOLD: begin
                if (!go_hold_s) begin
                    state_d = SEQ_STABLE;
                    cnt_d   = '0;
                end else begin
                    state_d = SEQ_HOLD;
                end
            end
            SEQ_STABLE: begin
                if (go_hold_s) begin
                    state_d = SEQ_HOLD;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = SEQ_REL0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SEQ_REL0: begin
                if (go_hold_s) begin
                    state_d = SEQ_HOLD;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = SEQ_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SEQ_RUN: begin
                if (go_hold_s) begin
                    state_d = SEQ_HOLD;
                end else begin
                    state_d = SEQ_RUN;
                end
            end
            default: begin
                state_d = SEQ_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Saturating lock-loss event counter.
    always_comb begin
        if (lost_s && (loss_q != 8'hFF)) begin
            loss_d = loss_q + 8'd1;
        end else begin
            loss_d = loss_q;
        end
    end

    // Lock synchroniser, FSM state and resets decoded from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            locked_q    <= 1'b0;
            state_q     <= SEQ_HOLD;
            cnt_q       <= '0;
            loss_q      <= 8'd0;
            rst_io_q    <= 1'b1;
            rst_cpu_q   <= 1'b1;
        end else begin
            lock_meta_q <= pll_locked;
            locked_q    <= lock_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            rst_io_q    <= (state_d == SEQ_HOLD) || (state_d == SEQ_STABLE);
            rst_cpu_q   <= (state_d != SEQ_RUN);
        end
    end

    assign rst_io          = rst_io_q;
    assign rst_cpu         = rst_cpu_q;
    assign seq_state       = state_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: expectations derived from the edge timing of the
// sequence are queued and then compared against the DUT outputs.
module tb_pll_reset_sequencer;
    import pll_reset_sequencer_pkg::*;

    localparam int LOCK_N = 8;
    localparam int GAP_N  = 4;
    localparam int DEB_N  = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b1;
    logic       btn_reset = 1'b0;
    logic       rst_io;
    logic       rst_cpu;
    logic [1:0] seq_state;
    logic [7:0] lock_loss_count;

    typedef struct {
        string      tag;
        logic       io;
        logic       cpu;
        logic [1:0] st;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_cnt = 8'd0;

    always #10 clock = ~clock;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES(LOCK_N),
        .STAGE_GAP         (GAP_N),
        .DEBOUNCE_CYCLES   (DEB_N)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .btn_reset      (btn_reset),
        .rst_io         (rst_io),
        .rst_cpu        (rst_cpu),
        .seq_state      (seq_state),
        .lock_loss_count(lock_loss_count)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic io, input logic cpu,
                            input logic [1:0] st, input logic [7:0] cnt);
        exp_t e;
        e.tag = tag; e.io = io; e.cpu = cpu; e.st = st; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb_q.pop_front();
        total++;
        assert (rst_io === e.io) else begin
            bad++; $error("FAIL %s rst_io observed=%b expected=%b", e.tag, rst_io, e.io);
        end
        total++;
        assert (rst_cpu === e.cpu) else begin
            bad++; $error("FAIL %s rst_cpu observed=%b expected=%b", e.tag, rst_cpu, e.cpu);
        end
        total++;
        assert (seq_state === e.st) else begin
            bad++; $error("FAIL %s seq_state observed=%0d expected=%0d", e.tag, seq_state, e.st);
        end
        total++;
        assert (lock_loss_count === e.cnt) else begin
            bad++; $error("FAIL %s lock_loss_count observed=%0d expected=%0d", e.tag, lock_loss_count, e.cnt);
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] st);
        push_exp(tag, (st == SEQ_HOLD) || (st == SEQ_STABLE), st != SEQ_RUN, st, exp_cnt);
        pop_check();
    endtask

    task automatic count_loss();
        if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
    endtask

    // E is e_off edges from now; rst_io falls at E+LOCK_N, rst_cpu at E+LOCK_N+GAP_N.
    task automatic run_seq(input string tag, input int e_off);
        if (e_off > 1) begin
            step(e_off - 1);
            chk({tag, "_hold"}, SEQ_HOLD);
        end
        step(1);            chk({tag, "_enter_stable"}, SEQ_STABLE);
        step(LOCK_N - 1);   chk({tag, "_last_stable"}, SEQ_STABLE);
        step(1);            chk({tag, "_io_release"}, SEQ_REL0);
        step(GAP_N - 1);    chk({tag, "_last_rel0"}, SEQ_REL0);
        step(1);            chk({tag, "_cpu_release"}, SEQ_RUN);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        exp_cnt = 8'd0;
        #1;
        chk("reset_pulse", SEQ_HOLD);
        step(2);
        reset_n = 1'b1;
    endtask

    initial begin
        // 1. power-up with lock present from the start
        step(5);
        chk("por", SEQ_HOLD);
        reset_n = 1'b1;
        run_seq("pwrup", 3);

        // 2. one-cycle lock glitch while the stability counter reads 5
        pulse_reset();
        step(3);            chk("gl_stable", SEQ_STABLE);
        step(5);            chk("gl_cnt5", SEQ_STABLE);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);            chk("gl_not_yet", SEQ_STABLE);
        step(1);            count_loss(); chk("gl_hold", SEQ_HOLD);
        run_seq("gl_relock", 1);

        // 3. repeated lock loss in RUN, saturating the counter
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            step(2);        chk("loss_lat2", SEQ_RUN);
            step(1);        count_loss(); chk("loss_lat3", SEQ_HOLD);
            pll_locked = 1'b1;
            step(15);       chk("loss_rerun", SEQ_RUN);
        end
        total++;
        assert (lock_loss_count === 8'd255) else begin
            bad++; $error("FAIL sat_255 observed=%0d expected=255", lock_loss_count);
        end

        // 4. button bounce rejected, steady press accepted without counting
        pulse_reset();
        run_seq("btn_pre", 3);
        for (int i = 0; i < 5; i++) begin
            btn_reset = 1'b1;
            step(2);        chk("bounce_hi", SEQ_RUN);
            btn_reset = 1'b0;
            step(2);        chk("bounce_lo", SEQ_RUN);
        end
        step(4);            chk("bounce_settle", SEQ_RUN);
        btn_reset = 1'b1;
        step(6);
        btn_reset = 1'b0;   chk("btn_not_yet", SEQ_RUN);
        step(1);            chk("btn_hold", SEQ_HOLD);
        run_seq("btn_release", 6);

        // 5. asynchronous reset while in REL0
        pll_locked = 1'b0;
        step(3);            count_loss(); chk("r5_loss", SEQ_HOLD);
        pll_locked = 1'b1;
        step(3);            chk("r5_stable", SEQ_STABLE);
        step(8);            chk("r5_rel0", SEQ_REL0);
        step(1);            chk("r5_rel0b", SEQ_REL0);
        #3;
        reset_n = 1'b0;
        exp_cnt = 8'd0;
        #1;                 chk("r5_async", SEQ_HOLD);
        step(2);
        reset_n = 1'b1;
        run_seq("r5_resequence", 3);

        // 6. lock loss and accepted button on the same edge
        btn_reset = 1'b1;
        step(4);
        pll_locked = 1'b0;
        step(2);            chk("sim_pre", SEQ_RUN);
        step(1);            count_loss(); chk("sim_hold", SEQ_HOLD);
        step(4);            chk("sim_hold_once", SEQ_HOLD);
        btn_reset = 1'b0;
        pll_locked = 1'b1;
        run_seq("sim_recover", 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
